board_updater: RTL and testbench

Owns the 192-bit board register (8x8 squares x 3 bits) that the square-status lookup logic reads. Accepts one board-edit command at a time over a valid/ready handshake: move a piece, set a square, reload the initial layout, or clear the board. It validates each command, applies it, and reports completion, errors and any captured piece. It sits directly upstream of the status lookup and drives its BoardState input.

---
 rtl/board_updater.sv | 171 +++++++++++++++++
 tb/tb_board_updater.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_updater.sv
// Board register owner: accepts one edit command at a time (MOVE, SET,
// LOAD_INIT, CLEAR_ALL), validates it, applies it and reports the outcome.
module board_updater #(
    parameter logic [191:0] INIT_BOARD = 192'h0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [3:0]   src_x,
    input  logic [3:0]   src_y,
    input  logic [3:0]   dst_x,
    input  logic [3:0]   dst_y,
    input  logic [2:0]   piece_in,
    output logic [191:0] BoardState,
    output logic         done,
    output logic         err,
    output logic [2:0]   captured,
    output logic [7:0]   move_count
);

    localparam int unsigned BOARD_W = 192;
    localparam int unsigned SQ_W    = 3;
    localparam int unsigned IDX_W   = 8;

    localparam logic [1:0] OP_MOVE  = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_WRITE,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [BOARD_W-1:0]   board_q, board_d;
    logic [1:0]           op_q, op_d;
    logic [3:0]           sx_q, sx_d, sy_q, sy_d, dx_q, dx_d, dy_q, dy_d;
    logic [SQ_W-1:0]      piece_q, piece_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [SQ_W-1:0]      cap_q, cap_d;
    logic [7:0]           cnt_q, cnt_d;

    logic [IDX_W-1:0]     src_bit_c, dst_bit_c;
    logic [SQ_W-1:0]      src_piece_c, dst_piece_c;
    logic                 reject_c;

    // Bit offsets of the latched source/destination squares and their contents
    always_comb begin
        src_bit_c   = IDX_W'({sy_q[2:0], sx_q[2:0]}) * IDX_W'(SQ_W);
        dst_bit_c   = IDX_W'({dy_q[2:0], dx_q[2:0]}) * IDX_W'(SQ_W);
        src_piece_c = board_q[src_bit_c +: SQ_W];
        dst_piece_c = board_q[dst_bit_c +: SQ_W];
    end

    // Command validation; whole-board ops are always accepted
    always_comb begin
        reject_c = 1'b0;
        case (op_q)
            OP_MOVE: reject_c = sx_q[3] | sy_q[3] | dx_q[3] | dy_q[3]
                              | (src_piece_c == '0)
                              | ((sx_q == dx_q) && (sy_q == dy_q));
            OP_SET:  reject_c = dx_q[3] | dy_q[3];
            default: reject_c = 1'b0;
        endcase
    end

    // Next-state, command latch and board update
    always_comb begin
        state_d = state_q;
        board_d = board_q;
        op_d    = op_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        piece_d = piece_q;
        err_d   = err_q;
        cap_d   = cap_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    op_d    = req_op;
                    sx_d    = src_x;
                    sy_d    = src_y;
                    dx_d    = dst_x;
                    dy_d    = dst_y;
                    piece_d = piece_in;
                    err_d   = 1'b0;
                    cap_d   = '0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                err_d   = reject_c;
                state_d = reject_c ? S_DONE : S_WRITE;
            end
            S_WRITE: begin
                case (op_q)
                    OP_MOVE: begin
                        board_d[dst_bit_c +: SQ_W] = src_piece_c;
                        board_d[src_bit_c +: SQ_W] = '0;
                        cap_d                      = dst_piece_c;
                        cnt_d                      = cnt_q + 8'd1;
                    end
                    OP_SET:   board_d[dst_bit_c +: SQ_W] = piece_q;
                    OP_LOAD:  board_d = INIT_BOARD;
                    OP_CLEAR: board_d = '0;
                    default:  board_d = board_q;
                endcase
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // State and datapath registers; reset abandons any command in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            board_q <= INIT_BOARD;
            op_q    <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            piece_q <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cap_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            op_q    <= op_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            piece_q <= piece_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready  = ready_q;
    assign BoardState = board_q;
    assign done       = done_q;
    assign err        = err_q;
    assign captured   = cap_q;
    assign move_count = cnt_q;

endmodule

// File: tb/tb_board_updater.sv
// Bench for board_updater: directed vector table, handshake/reset sequences
// and random commands against a square-array reference model.
module tb_board_updater;

    localparam logic [191:0] INIT = {64{3'b001}};
    localparam logic [2:0]   INIT_SQ = 3'b001;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [3:0]   src_x, src_y, dst_x, dst_y;
    logic [2:0]   piece_in;
    logic [191:0] BoardState;
    logic         done;
    logic         err;
    logic [2:0]   captured;
    logic [7:0]   move_count;

    board_updater #(.INIT_BOARD(INIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .src_x(src_x), .src_y(src_y), .dst_x(dst_x), .dst_y(dst_y),
        .piece_in(piece_in), .BoardState(BoardState), .done(done),
        .err(err), .captured(captured), .move_count(move_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model: one entry per square, plus the move counter
    logic [2:0] m_board [64];
    int         m_mc;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [191:0] m_pack();
        logic [191:0] v;
        for (int i = 0; i < 64; i++) v[i*3 +: 3] = m_board[i];
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) m_board[i] = INIT_SQ;
        m_mc = 0;
    endtask

    task automatic model_cmd(input logic [1:0] op, input logic [3:0] sx, sy, dx, dy,
                             input logic [2:0] p, output logic e, output logic [2:0] cap);
        int s, d;
        e = 1'b0;
        cap = 3'b000;
        s = int'(sy) * 8 + int'(sx);
        d = int'(dy) * 8 + int'(dx);
        case (op)
            2'b00: begin
                if (sx > 7 || sy > 7 || dx > 7 || dy > 7) e = 1'b1;
                else if (m_board[s] == 3'b000 || s == d) e = 1'b1;
                else begin
                    cap = m_board[d];
                    m_board[d] = m_board[s];
                    m_board[s] = 3'b000;
                    m_mc = (m_mc + 1) % 256;
                end
            end
            2'b01: begin
                if (dx > 7 || dy > 7) e = 1'b1;
                else m_board[d] = p;
            end
            2'b10: for (int i = 0; i < 64; i++) m_board[i] = INIT_SQ;
            default: for (int i = 0; i < 64; i++) m_board[i] = 3'b000;
        endcase
    endtask

    // Drive one command, return the outcome seen in the done cycle
    task automatic do_cmd(input logic [1:0] op, input logic [3:0] sx, sy, dx, dy,
                          input logic [2:0] p, output logic e, output logic [2:0] cap,
                          output int lat, output logic [191:0] bd);
        bit acc;
        e = 1'bx; cap = 3'bxxx; lat = 0; bd = 'x;
        @(negedge clk);
        req_op = op; src_x = sx; src_y = sy; dst_x = dx; dst_y = dy; piece_in = p;
        req_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                @(posedge clk);
                acc = 1;
                break;
            end
            @(negedge clk);
        end
        #1;
        req_valid = 1'b0;
        req_op = 2'($urandom); src_x = 4'($urandom); src_y = 4'($urandom);
        dst_x = 4'($urandom); dst_y = 4'($urandom); piece_in = 3'($urandom);
        if (!acc) begin
            chk("accept_timeout", 192'(0), 192'(1));
            return;
        end
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n + 1;
                break;
            end
        end
        e = err;
        cap = captured;
        bd = BoardState;
        @(posedge clk); #1;
        chk("done_one_pulse", 192'(done), 192'(0));
        chk("err_hold", 192'(err), 192'(e));
        chk("captured_hold", 192'(captured), 192'(cap));
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [3:0] sx, sy, dx, dy,
                           input logic [2:0] p, output logic e, output logic [2:0] cap);
        logic me;
        logic [2:0] mcap;
        int lat;
        logic [191:0] bd;
        model_cmd(op, sx, sy, dx, dy, p, me, mcap);
        do_cmd(op, sx, sy, dx, dy, p, e, cap, lat, bd);
        chk("err", 192'(e), 192'(me));
        chk("captured", 192'(cap), 192'(mcap));
        chk("latency", 192'(lat), me ? 192'(2) : 192'(3));
        chk("board", bd, m_pack());
        chk("move_count", 192'(move_count), 192'(m_mc));
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] sx, sy, dx, dy;
        logic [2:0] p;
        logic       exp_err;
        logic [2:0] exp_cap;
        logic [7:0] exp_mc;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic e;
        logic [2:0] cap;
        int acc_c [$];
        logic [191:0] done_bd [$];
        int last_acc;
        int done_seen;
        bit ready_before;

        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00;
        src_x = 0; src_y = 0; dst_x = 0; dst_y = 0; piece_in = 0;
        m_reset();

        tbl[0]  = '{2'b01, 4'd0, 4'd0, 4'd3, 4'd4, 3'b101, 1'b0, 3'b000, 8'd0};
        tbl[1]  = '{2'b11, 4'd9, 4'd9, 4'd9, 4'd9, 3'b111, 1'b0, 3'b000, 8'd0};
        tbl[2]  = '{2'b01, 4'd0, 4'd0, 4'd0, 4'd0, 3'b010, 1'b0, 3'b000, 8'd0};
        tbl[3]  = '{2'b01, 4'd0, 4'd0, 4'd3, 4'd4, 3'b101, 1'b0, 3'b000, 8'd0};
        tbl[4]  = '{2'b00, 4'd3, 4'd4, 4'd0, 4'd0, 3'b000, 1'b0, 3'b010, 8'd1};
        tbl[5]  = '{2'b00, 4'd7, 4'd7, 4'd1, 4'd1, 3'b000, 1'b1, 3'b000, 8'd1};
        tbl[6]  = '{2'b01, 4'd0, 4'd0, 4'd2, 4'd2, 3'b011, 1'b0, 3'b000, 8'd1};
        tbl[7]  = '{2'b00, 4'd2, 4'd2, 4'd2, 4'd2, 3'b000, 1'b1, 3'b000, 8'd1};
        tbl[8]  = '{2'b00, 4'd8, 4'd0, 4'd1, 4'd1, 3'b000, 1'b1, 3'b000, 8'd1};
        tbl[9]  = '{2'b01, 4'd0, 4'd0, 4'd9, 4'd1, 3'b110, 1'b1, 3'b000, 8'd1};
        tbl[10] = '{2'b10, 4'd15, 4'd15, 4'd12, 4'd8, 3'b000, 1'b0, 3'b000, 8'd1};
        tbl[11] = '{2'b00, 4'd0, 4'd0, 4'd0, 4'd1, 3'b000, 1'b0, 3'b001, 8'd2};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_board", BoardState, INIT);
        chk("reset_ready", 192'(req_ready), 192'(1));
        chk("reset_done", 192'(done), 192'(0));
        chk("reset_err", 192'(err), 192'(0));
        chk("reset_captured", 192'(captured), 192'(0));
        chk("reset_move_count", 192'(move_count), 192'(0));

        // directed vector table
        for (int i = 0; i < 12; i++) begin
            run_cmd(tbl[i].op, tbl[i].sx, tbl[i].sy, tbl[i].dx, tbl[i].dy, tbl[i].p, e, cap);
            chk("tbl_err", 192'(e), 192'(tbl[i].exp_err));
            chk("tbl_captured", 192'(cap), 192'(tbl[i].exp_cap));
            chk("tbl_move_count", 192'(move_count), 192'(tbl[i].exp_mc));
            if (i == 0) chk("set_sq34", 192'(BoardState[107:105]), 192'(3'b101));
            if (i == 4) begin
                chk("move_src_cleared", 192'(BoardState[107:105]), 192'(0));
                chk("move_dst_written", 192'(BoardState[2:0]), 192'(3'b101));
            end
        end

        // req_valid held high: CLEAR_ALL then LOAD_INIT, back-to-back accepts
        @(negedge clk);
        req_op = 2'b11; req_valid = 1'b1;
        last_acc = -100;
        for (int c = 0; c < 10; c++) begin
            ready_before = req_ready;
            @(posedge clk);
            if (ready_before) begin
                acc_c.push_back(c);
                last_acc = c;
            end
            #1;
            if (acc_c.size() >= 1) req_op = 2'b10;
            if (done) done_bd.push_back(BoardState);
            if (acc_c.size() >= 1)
                chk("held_ready", 192'(req_ready), (c - last_acc == 3) ? 192'(1) : 192'(0));
        end
        @(negedge clk);
        req_valid = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (done) done_bd.push_back(BoardState);
        end
        chk("held_accepts", 192'(acc_c.size()), 192'(3));
        if (acc_c.size() >= 2) chk("held_spacing", 192'(acc_c[1] - acc_c[0]), 192'(4));
        chk("held_dones", 192'(done_bd.size()), 192'(3));
        if (done_bd.size() >= 2) begin
            chk("held_board_clear", done_bd[0], 192'(0));
            chk("held_board_init", done_bd[1], INIT);
        end
        for (int i = 0; i < 64; i++) m_board[i] = INIT_SQ;
        chk("held_final_board", BoardState, m_pack());

        // reset asserted during WRITE of a MOVE
        run_cmd(2'b01, 4'd0, 4'd0, 4'd5, 4'd5, 3'b111, e, cap);
        @(negedge clk);
        req_op = 2'b00; src_x = 1; src_y = 1; dst_x = 2; dst_y = 2; req_valid = 1'b1;
        chk("rst_pre_ready", 192'(req_ready), 192'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_board", BoardState, INIT);
        chk("rst_mid_move_count", 192'(move_count), 192'(0));
        chk("rst_mid_done", 192'(done), 192'(0));
        chk("rst_mid_ready", 192'(req_ready), 192'(1));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        chk("rst_no_done", 192'(done_seen), 192'(0));
        chk("rst_board_kept", BoardState, INIT);
        m_reset();
        run_cmd(2'b01, 4'd0, 4'd0, 4'd0, 4'd7, 3'b110, e, cap);

        // randomized commands against the model
        for (int k = 0; k < 150; k++) begin
            int r;
            logic [1:0] op;
            r = int'($urandom_range(0, 9));
            op = (r < 5) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
            run_cmd(op, 4'($urandom_range(0, 8)), 4'($urandom_range(0, 8)),
                    4'($urandom_range(0, 8)), 4'($urandom_range(0, 8)),
                    3'($urandom), e, cap);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
